// File: rtl/lfsr_rng_arbiter.sv
// One shared 20-bit Fibonacci LFSR with a round-robin arbiter that serves its
// words to several requesters, plus reseed sequencing and a post-seed warm-up.
module lfsr_rng_arbiter #(
    parameter int          N_REQ  = 4,
    parameter logic [19:0] SEED   = 20'hBEEF5,
    parameter int          WARMUP = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [19:0]      rnd,
    input  logic             reseed_req,
    input  logic [19:0]      reseed_val,
    output logic             reseed_ack,
    output logic             busy
);

    // Handshake: each requester holds req high while it wants a word; a
    // one-cycle gnt bit marks the cycle in which rnd carries that requester's
    // word. reseed_req is sampled every cycle; reseed_ack pulses on the load.

    localparam int          PW         = $clog2(N_REQ);
    localparam bit          HAS_WARMUP = (WARMUP > 0);
    localparam logic [7:0]  WARM_LAST  = HAS_WARMUP ? 8'(WARMUP - 1) : 8'd0;
    localparam logic [N_REQ-1:0] ONE   = N_REQ'(1);

    // busy is the externally visible copy of this state register.
    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_SERVE  = 1'b1
    } state_t;

    localparam state_t ST_INIT = HAS_WARMUP ? ST_WARMUP : ST_SERVE;

    state_t          state;
    logic [19:0]     s;
    logic [19:0]     s_step;
    logic [7:0]      cnt;
    logic [PW-1:0]   last;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   cand;
    logic            found;
    int              idx;

    assign s_step = {s[18:0], s[19] ^ s[16]};

    // Rotating priority search starting just after the previous winner.
    always_comb begin
        winner = last;
        found  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(last) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = PW'(idx);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s          <= SEED;
            state      <= ST_INIT;
            cnt        <= 8'd0;
            last       <= PW'(N_REQ - 1);
            gnt        <= '0;
            rnd        <= 20'd0;
            reseed_ack <= 1'b0;
            busy       <= HAS_WARMUP;
        end else begin
            gnt        <= '0;
            reseed_ack <= 1'b0;
            if (reseed_req) begin
                // Reseed wins over a grant; the requester simply retries.
                s          <= (reseed_val == 20'd0) ? SEED : reseed_val;
                reseed_ack <= 1'b1;
                cnt        <= 8'd0;
                state      <= ST_INIT;
                busy       <= HAS_WARMUP;
            end else if (state == ST_WARMUP) begin
                s <= s_step;
                if (cnt == WARM_LAST) begin
                    cnt   <= 8'd0;
                    state <= ST_SERVE;
                    busy  <= 1'b0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else if (found) begin
                gnt  <= ONE << winner;
                rnd  <= s;
                last <= winner;
                s    <= s_step;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Bench for lfsr_rng_arbiter: directed literal checks on a WARMUP=0 instance
// and a randomized, model-checked run on a WARMUP=8 instance.
module tb_lfsr_rng_arbiter;

    localparam logic [19:0] B_SEED   = 20'hBEEF5;
    localparam int          B_WARMUP = 8;
    localparam int          NR       = 4;

    logic        clk;
    logic        nrst_a, nrst_b;
    logic [3:0]  req_a, req_b, gnt_a, gnt_b;
    logic [19:0] rnd_a, rnd_b, rv_a, rv_b;
    logic        rs_a, rs_b, ack_a, ack_b, busy_a, busy_b;

    int n_checks = 0;
    int n_err    = 0;
    bit b_chk    = 1'b0;

    // Reference model of instance b, kept at the level of the behavioural rules.
    logic [19:0] m_s, m_rnd;
    logic [3:0]  m_gnt;
    logic        m_ack, m_busy;
    int          m_warm, m_last;

    lfsr_rng_arbiter #(.N_REQ(4), .SEED(20'h00001), .WARMUP(0)) dut_a (
        .CLK(clk), .nRST(nrst_a), .req(req_a), .gnt(gnt_a), .rnd(rnd_a),
        .reseed_req(rs_a), .reseed_val(rv_a), .reseed_ack(ack_a), .busy(busy_a)
    );

    lfsr_rng_arbiter #(.N_REQ(NR), .SEED(B_SEED), .WARMUP(B_WARMUP)) dut_b (
        .CLK(clk), .nRST(nrst_b), .req(req_b), .gnt(gnt_b), .rnd(rnd_b),
        .reseed_req(rs_b), .reseed_val(rv_b), .reseed_ack(ack_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] lfsr_step(input logic [19:0] x);
        return {x[18:0], x[19] ^ x[16]};
    endfunction

    task automatic model_reset();
        m_s    = B_SEED;
        m_rnd  = 20'd0;
        m_gnt  = 4'd0;
        m_ack  = 1'b0;
        m_warm = B_WARMUP;
        m_busy = (B_WARMUP > 0);
        m_last = NR - 1;
    endtask

    task automatic model_update();
        int w;
        if (!nrst_b) return;
        m_ack = 1'b0;
        m_gnt = 4'd0;
        if (rs_b) begin
            m_s    = (rv_b == 20'd0) ? B_SEED : rv_b;
            m_ack  = 1'b1;
            m_warm = B_WARMUP;
        end else if (m_warm > 0) begin
            m_s    = lfsr_step(m_s);
            m_warm = m_warm - 1;
        end else if (req_b != 4'd0) begin
            w = -1;
            for (int k = 1; k <= NR; k++) begin
                if (w < 0 && req_b[(m_last + k) % NR]) w = (m_last + k) % NR;
            end
            m_gnt[w] = 1'b1;
            m_rnd    = m_s;
            m_last   = w;
            m_s      = lfsr_step(m_s);
        end
        m_busy = (m_warm > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Async reset of instance b mid-cycle, checked before any clock edge.
    task automatic b_async_reset();
        #1 nrst_b = 1'b0;
        model_reset();
        #1;
        chk("b_rst_gnt", 32'(gnt_b), 32'd0);
        chk("b_rst_rnd", 32'(rnd_b), 32'd0);
        chk("b_rst_ack", 32'(ack_b), 32'd0);
        chk("b_rst_busy", 32'(busy_b), 32'd1);
        tick();
        nrst_b = 1'b1;
    endtask

    always @(negedge clk) begin
        if (b_chk) begin
            chk("b_gnt", 32'(gnt_b), 32'(m_gnt));
            chk("b_rnd", 32'(rnd_b), 32'(m_rnd));
            chk("b_ack", 32'(ack_b), 32'(m_ack));
            chk("b_busy", 32'(busy_b), 32'(m_busy));
        end
    end

    initial begin
        logic [3:0]  exp_g[$];
        logic [19:0] exp_r[$];
        nrst_a = 1'b0; nrst_b = 1'b0;
        req_a = 4'd0; req_b = 4'd0;
        rs_a = 1'b0; rs_b = 1'b0;
        rv_a = 20'd0; rv_b = 20'd0;
        model_reset();
        tick();
        tick();
        b_chk = 1'b1;

        chk("a_reset_gnt", 32'(gnt_a), 32'd0);
        chk("a_reset_rnd", 32'(rnd_a), 32'd0);
        chk("a_reset_ack", 32'(ack_a), 32'd0);
        chk("a_reset_busy", 32'(busy_a), 32'd0);
        chk("b_reset_busy", 32'(busy_b), 32'd1);

        // Instance a, SEED=1: single requester, then alternating pair.
        nrst_a = 1'b1;
        req_a  = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("a_single_gnt", 32'(gnt_a), 32'h1);
            chk("a_single_rnd", 32'(rnd_a), 32'(20'h1 << i));
        end
        req_a = 4'b1010;
        exp_g = '{4'b0010, 4'b1000, 4'b0010};
        exp_r = '{20'h8, 20'h10, 20'h20};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("a_pair_gnt", 32'(gnt_a), 32'(exp_g[i]));
            chk("a_pair_rnd", 32'(rnd_a), 32'(exp_r[i]));
        end
        req_a = 4'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("a_idle_gnt", 32'(gnt_a), 32'd0);
            chk("a_idle_rnd", 32'(rnd_a), 32'h20);
        end
        req_a = 4'b0001;
        tick();
        chk("a_frozen_gnt", 32'(gnt_a), 32'h1);
        chk("a_frozen_rnd", 32'(rnd_a), 32'h40);

        // Zero reseed falls back to SEED; reseed beats the pending grant.
        rs_a = 1'b1; rv_a = 20'd0;
        tick();
        chk("a_rs0_ack", 32'(ack_a), 32'd1);
        chk("a_rs0_gnt", 32'(gnt_a), 32'd0);
        chk("a_rs0_rnd", 32'(rnd_a), 32'h40);
        rs_a = 1'b0;
        tick();
        chk("a_rs0_next_ack", 32'(ack_a), 32'd0);
        chk("a_rs0_next_gnt", 32'(gnt_a), 32'h1);
        chk("a_rs0_next_rnd", 32'(rnd_a), 32'h1);

        // Async reset mid-grant, then req[0] regains priority.
        rs_a = 1'b1; rv_a = 20'h00005; req_a = 4'b0010;
        tick();
        chk("a_rs5_ack", 32'(ack_a), 32'd1);
        chk("a_rs5_gnt", 32'(gnt_a), 32'd0);
        rs_a = 1'b0;
        tick();
        chk("a_pre_rst_gnt", 32'(gnt_a), 32'h2);
        chk("a_pre_rst_rnd", 32'(rnd_a), 32'h5);
        #1 nrst_a = 1'b0;
        #1;
        chk("a_async_gnt", 32'(gnt_a), 32'd0);
        chk("a_async_rnd", 32'(rnd_a), 32'd0);
        chk("a_async_ack", 32'(ack_a), 32'd0);
        tick();
        nrst_a = 1'b1;
        req_a  = 4'b0011;
        tick();
        chk("a_post_rst_gnt", 32'(gnt_a), 32'h1);
        chk("a_post_rst_rnd", 32'(rnd_a), 32'h1);
        tick();
        chk("a_post_rst_gnt2", 32'(gnt_a), 32'h2);
        chk("a_post_rst_rnd2", 32'(rnd_a), 32'h2);
        req_a = 4'd0;

        // Instance b: warm-up after reset, then full round robin.
        req_b  = 4'b1111;
        nrst_b = 1'b1;
        chk("b_warm0_busy", 32'(busy_b), 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("b_warm_busy", 32'(busy_b), 32'd1);
            chk("b_warm_gnt", 32'(gnt_b), 32'd0);
        end
        tick();
        chk("b_warm_end_busy", 32'(busy_b), 32'd0);
        chk("b_warm_end_gnt", 32'(gnt_b), 32'd0);
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b_rr_gnt", 32'(gnt_b), 32'(exp_g[i]));
            if (i == 0) chk("b_first_rnd", 32'(rnd_b), 32'h000EF549);
            if (i == 1) chk("b_second_rnd", 32'(rnd_b), 32'h000DEA93);
        end

        // Reseed at warm-up cycle 5 restarts the warm-up.
        b_async_reset();
        for (int i = 0; i < 5; i++) tick();
        rs_b = 1'b1; rv_b = 20'h12345;
        tick();
        chk("b_rs_ack", 32'(ack_b), 32'd1);
        chk("b_rs_busy", 32'(busy_b), 32'd1);
        rs_b = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("b_rewarm_busy", 32'(busy_b), 32'd1);
        end
        tick();
        chk("b_rewarm_end_busy", 32'(busy_b), 32'd0);
        tick();
        chk("b_rs_first_gnt", 32'(gnt_b), 32'h1);
        chk("b_rs_first_rnd", 32'(rnd_b), 32'h00034583);

        // Randomized traffic with occasional reseeds and async resets.
        for (int i = 0; i < 600; i++) begin
            req_b = 4'($urandom_range(0, 15));
            rs_b  = ($urandom_range(0, 29) == 0);
            rv_b  = ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom_range(0, 20'hFFFFF));
            if ($urandom_range(0, 149) == 0) b_async_reset();
            tick();
        end
        rs_b = 1'b0;
        req_b = 4'd0;
        tick();
        b_chk = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
